// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word, opcode and register-index types for the pipeline
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef logic [6:0]  rv32i_opcode;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } rv32i_reg_word;
    localparam rv32i_opcode OP_IMM    = 7'b0010011;
    localparam rv32i_word   NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, HOLD, KILL} fetch_state_t;
endpackage

// File: rtl/if_predecode.sv
// if_predecode: slices a 32-bit instruction into opcode, funct fields and register indices
module if_predecode
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [14:0] regs
);
    rv32i_reg_word r;
    assign r      = '{rs1: instr[19:15], rs2: instr[24:20], rd: instr[11:7]};
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign regs   = r;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with PC, imem handshake, stall hold buffer and redirect kill
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        load_id,
    output logic [31:0] pc_if,
    output logic [31:0] instr_if,
    output logic [6:0]  opcode_if,
    output logic [2:0]  funct3_if,
    output logic [6:0]  funct7_if,
    output logic [14:0] regs_if
);
    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d, req_q, req_d, buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_q       <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign imem_read    = !rst && state_q != HOLD;
    assign imem_address = req_q;
    assign load_id      = !stall || redirect_valid || rst;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_if    = NOP_INSTR;
        pc_if       = '0;
        if (!rst) begin
            if (redirect_valid) begin
                pc_d = {redirect_pc[31:2], 2'b00};
                // An answered (or never issued) request can be retargeted now; otherwise wait it out
                if (state_q == HOLD || (state_q == FETCH && imem_resp)) begin
                    req_d   = pc_d;
                    state_d = FETCH;
                end else begin
                    state_d = KILL;
                end
            end else if (state_q == FETCH && imem_resp && stall) begin
                buf_instr_d = imem_rdata;
                buf_pc_d    = req_q;
                state_d     = HOLD;
            end else if (state_q == FETCH && imem_resp) begin
                instr_if = imem_rdata;
                pc_if    = req_q;
                pc_d     = req_q + 32'd4;
                req_d    = req_q + 32'd4;
            end else if (state_q == HOLD) begin
                instr_if = buf_instr_q;
                pc_if    = buf_pc_q;
                pc_d     = stall ? pc_q : buf_pc_q + 32'd4;
                req_d    = stall ? req_q : buf_pc_q + 32'd4;
                state_d  = stall ? HOLD : FETCH;
            end else if (state_q == KILL && imem_resp) begin
                req_d   = pc_q;
                state_d = FETCH;
            end
        end
    end

    if_predecode u_predecode (
        .instr  (instr_if),
        .opcode (opcode_if),
        .funct3 (funct3_if),
        .funct7 (funct7_if),
        .regs   (regs_if)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps with hand-computed expectations for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_resp;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_read, load_id;
    logic [31:0] imem_address, pc_if, instr_if;
    logic [6:0]  opcode_if, funct7_if;
    logic [2:0]  funct3_if;
    logic [14:0] regs_if;
    int total = 0;
    int bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h0050_0093;
    localparam logic [31:0] I2  = 32'h0020_81B3;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .load_id(load_id),
        .pc_if(pc_if), .instr_if(instr_if), .opcode_if(opcode_if),
        .funct3_if(funct3_if), .funct7_if(funct7_if), .regs_if(regs_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                         input logic rsp, input logic [31:0] rd);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp; imem_resp = rsp; imem_rdata = rd;
        #1;
    endtask

    task automatic look(input string tag, input logic rd, input logic [31:0] addr, input logic ld,
                        input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, "/imem_read"}, {31'd0, imem_read}, {31'd0, rd});
        if (rd) chk({tag, "/imem_address"}, imem_address, addr);
        chk({tag, "/load_id"}, {31'd0, load_id}, {31'd0, ld});
        chk({tag, "/instr_if"}, instr_if, ins);
        chk({tag, "/pc_if"}, pc_if, pc);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        look("rst", 0, 0, 1, NOP, 0);
        drive(1, 0, 0, 0, 1, I1);
        look("rst_resp", 0, 0, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("f0_wait", 1, 32'h4000_0000, 1, NOP, 0);
        chk("f0_wait/opcode", {25'd0, opcode_if}, 32'h13);
        drive(0, 0, 0, 0, 1, I1);
        look("f0_resp", 1, 32'h4000_0000, 1, I1, 32'h4000_0000);
        chk("f0_resp/regs", {17'd0, regs_if}, 32'h00A1);
        chk("f0_resp/opcode", {25'd0, opcode_if}, 32'h13);
        chk("f0_resp/funct3", {29'd0, funct3_if}, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        look("f1_wait", 1, 32'h4000_0004, 1, NOP, 0);
        drive(0, 1, 0, 0, 1, I2);
        chk("stall_resp/imem_read", {31'd0, imem_read}, 32'd1);
        chk("stall_resp/load_id", {31'd0, load_id}, 32'd0);
        chk("stall_resp/imem_address", imem_address, 32'h4000_0004);
        drive(0, 1, 0, 0, 0, 0);
        look("hold1", 0, 0, 0, I2, 32'h4000_0004);
        drive(0, 1, 0, 0, 0, 0);
        look("hold2", 0, 0, 0, I2, 32'h4000_0004);
        drive(0, 0, 0, 0, 0, 0);
        look("hold_rel", 0, 0, 1, I2, 32'h4000_0004);
        chk("hold_rel/regs", {17'd0, regs_if}, 32'h0443);
        chk("hold_rel/opcode", {25'd0, opcode_if}, 32'h33);
        chk("hold_rel/funct7", {25'd0, funct7_if}, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        look("f2_wait", 1, 32'h4000_0008, 1, NOP, 0);
        drive(0, 0, 0, 0, 1, I1);
        look("f2_resp", 1, 32'h4000_0008, 1, I1, 32'h4000_0008);
        drive(0, 0, 0, 0, 1, I1);
        look("f3_resp", 1, 32'h4000_000C, 1, I1, 32'h4000_000C);
        drive(0, 0, 1, 32'h4000_0102, 0, 0);
        look("kill_in", 1, 32'h4000_0010, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("kill_wait", 1, 32'h4000_0010, 1, NOP, 0);
        drive(0, 0, 0, 0, 1, 32'h0010_0113);
        look("kill_resp", 1, 32'h4000_0010, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("after_kill", 1, 32'h4000_0100, 1, NOP, 0);
        drive(0, 1, 1, 32'h4000_0200, 1, I1);
        look("redir_resp", 1, 32'h4000_0100, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("redir_tgt", 1, 32'h4000_0200, 1, NOP, 0);
        drive(0, 1, 0, 0, 1, I2);
        chk("hold_in/load_id", {31'd0, load_id}, 32'd0);
        drive(0, 1, 1, 32'h4000_0300, 0, 0);
        look("hold_redir", 0, 0, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("hold_redir_tgt", 1, 32'h4000_0300, 1, NOP, 0);
        drive(0, 0, 1, 32'h4000_0400, 0, 0);
        look("kill2_in", 1, 32'h4000_0300, 1, NOP, 0);
        drive(1, 0, 0, 0, 0, 0);
        look("kill_rst", 0, 0, 1, NOP, 0);
        drive(0, 0, 0, 0, 0, 0);
        look("rst_rel", 1, 32'h4000_0000, 1, NOP, 0);
        drive(0, 0, 1, 32'hFFFF_FFFF, 1, I1);
        look("wrap_redir", 1, 32'h4000_0000, 1, NOP, 0);
        drive(0, 0, 0, 0, 1, I1);
        look("wrap_top", 1, 32'hFFFF_FFFC, 1, I1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0);
        look("wrap_zero", 1, 32'h0000_0000, 1, NOP, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
